pipeline_skid_stage: RTL and testbench
======================================

Name: pipeline_skid_stage

Overview:
- Generic, parametrised successor to the fixed stall/clear pipeline register: one pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer.
- in_ready is driven straight from a flop, so no combinational path runs from out_ready to in_ready. This lets long stall chains (IF->ID->EX...) close timing.
- Flush kills in-flight content and presents a bubble value, for example the NOP 0x0000_0033.
- One instance per pipeline boundary; the payload is the concatenation of all stage fields (instr, PC, PC+4, ...).

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- BUBBLE_VALUE, {WIDTH{1'b0}}, value driven on out_data after reset, after flush and whenever the stage is empty.
- CNT_W, 16, stall-counter width; used only with PIPE_STALL_CNT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all stage content; highest priority after reset.
- in_valid  in  1  upstream has data.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds data for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream; registered.
- stall_cnt  out  CNT_W  present only with PIPE_STALL_CNT_EN.

Behaviour:
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Storage: main register (out_data/out_valid) plus skid register (skid_data/skid_valid).
- State encoding:
  - EMPTY (main 0, skid 0)
  - ONE (main 1, skid 0)
  - FULL (main 1, skid 1)
- in_ready = ~skid_valid, taken directly from the flop.
- Reset (async, n_rst=0):
  - state EMPTY; out_valid=0; out_data=BUBBLE_VALUE; skid_data=BUBBLE_VALUE; in_ready=1.
  - stall_cnt=0.
- Transitions (no flush):
  - EMPTY + in-transfer -> ONE; out_data<=in_data.
  - ONE + in-transfer + out-transfer -> ONE; out_data<=in_data. This is the 1 item/cycle throughput path.
  - ONE + in-transfer, no out-transfer -> FULL; skid_data<=in_data; out_data holds.
  - ONE + out-transfer, no in-transfer -> EMPTY; out_data<=BUBBLE_VALUE.
  - FULL + out-transfer -> ONE; out_data<=skid_data; skid_valid<=0. No input is accepted in FULL.
  - Any other combination: hold all state.
- Latency:
  - 1 cycle from in-transfer to out_valid when EMPTY, or when ONE with a simultaneous drain.
  - Ordering is strictly FIFO.
- Stable payload: while out_valid=1 and out_ready=0, out_data is held stable.
- Flush:
  - Next state EMPTY; out_data and skid_data load BUBBLE_VALUE.
  - Any in-transfer in the flush cycle is discarded, even though in_ready may read 1.
  - Any out-transfer in the flush cycle still counts as completed downstream.
- Empty-stage payload: out_data equals BUBBLE_VALUE whenever out_valid=0. Decode stages may therefore read out_data without qualifying it by out_valid.
- Upstream protocol (not checked by the stage): once in_valid is asserted it stays asserted with in_data stable until in_ready.
- Reset mid-operation: asynchronous; all content lost immediately, with outputs at reset values in the same cycle.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; cleared only by reset (flush does not clear it).
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold n_rst=0 with in_valid=1, in_data=0x1234 -> out_valid=0, out_data=BUBBLE_VALUE (set to 0x0000_0033), in_ready=1. Release reset -> out_valid=1 one cycle after the first edge with in_valid=1.
- Streaming: out_ready=1 constant; push 0x1000_0000, 0x1000_0004, 0x1000_0008 back-to-back -> same values emerge in order, one per cycle, 1-cycle latency, in_ready always 1.
- Skid/backpressure:
  - Push A=0xA, B=0xB with out_ready=0 -> after 2 edges, FULL and in_ready=0. C=0xC is held off and out_data=0xA stable.
  - Raise out_ready -> A, B, C emerge in order with no drop or duplicate.
- Flush while FULL, with in_valid=1 and in_data=0xD in the same cycle -> next cycle out_valid=0, out_data=0x0000_0033, in_ready=1, and 0xD never appears.
- Drain to empty: single item 0x55, out_ready=1 -> after it leaves, out_valid=0 and out_data=BUBBLE_VALUE.
- With PIPE_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Flush -> stall_cnt stays 15. Reset -> stall_cnt=0.

Source files
------------

// File: rtl/pipeline_skid_stage.sv
// Pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Optional stall counter port enabled by defining PIPE_STALL_CNT_EN.
module pipeline_skid_stage #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // bit0 = main valid, bit1 = skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // Handshake flags come straight from state flops
  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = data_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // State, main and skid registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      data_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and datapath selection
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      data_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            data_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            data_d = in_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
            data_d  = BUBBLE_VALUE;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            data_d  = skid_q;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          data_d  = BUBBLE_VALUE;
          skid_d  = BUBBLE_VALUE;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  assign stall_cnt = cnt_q;

  // Saturating count of stalled cycles; only reset clears it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Testbench for pipeline_skid_stage: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pipeline_skid_stage;

  localparam int          W   = 32;
  localparam logic [31:0] BUB = 32'h0000_0033;
  localparam int          CW  = 4;
  localparam int          SAT = 15;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // reference model: FIFO of up to two items plus a stall counter
  logic [W-1:0] mq[$];
  int           mcnt;
  logic [W-1:0] emitted[$];

  pipeline_skid_stage #(
    .WIDTH       (W),
    .BUBBLE_VALUE(BUB),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_data();
    return (mq.size() > 0) ? mq[0] : BUB;
  endfunction

  // advance one clock edge, updating the model from pre-edge inputs
  task automatic cycle();
    bit itx, otx;
    itx = n_rst && in_valid && (mq.size() < 2);
    otx = n_rst && (mq.size() > 0) && out_ready;
    if (n_rst && mq.size() > 0 && !out_ready && mcnt < SAT) mcnt++;
    @(posedge clk);
    if (!n_rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (otx) emitted.push_back(mq.pop_front());
      if (flush) mq.delete();
      else if (itx) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    mq.delete();
    mcnt = 0;
    cycle();
    n_rst = 1'b1;
    emitted.delete();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h1234;
    mq.delete();
    mcnt = 0;
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== BUB) begin
      errors++;
      $display("FAIL reset_data: got %h want %h", out_data, BUB);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
`ifdef PIPE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
`endif
    n_rst = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234) begin
      errors++;
      $display("FAIL reset_release: got v=%b d=%h want v=1 d=00001234",
               out_valid, out_data);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals[3];
    vals = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = vals[i];
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, out_valid, out_data, in_ready, vals[i]);
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== BUB) begin
      errors++;
      $display("FAIL stream_end: got v=%b d=%h want v=0 d=%h",
               out_valid, out_data, BUB);
    end
    checks++;
    if (emitted.size() != 3 || emitted[0] !== vals[0] ||
        emitted[2] !== vals[2]) begin
      errors++;
      $display("FAIL stream_order: got %0d items want 3", emitted.size());
    end
  endtask

  task automatic test_skid();
    logic [W-1:0] want[3];
    want = '{32'hA, 32'hB, 32'hC};
    do_reset();
    in_valid = 1'b1;
    in_data = 32'hA;
    cycle();
    in_data = 32'hB;
    cycle();
    in_data = 32'hC;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL skid_full: got r=%b v=%b d=%h want r=0 v=1 d=0000000a",
               in_ready, out_valid, out_data);
    end
    cycle();
    cycle();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL skid_hold: got r=%b d=%h want r=0 d=0000000a",
               in_ready, out_data);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_data !== 32'hB || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain_b: got d=%h r=%b want d=0000000b r=1",
               out_data, in_ready);
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'hC || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain_c: got v=%b d=%h want v=1 d=0000000c",
               out_valid, out_data);
    end
    cycle();
    checks++;
    if (emitted.size() != 3 || emitted[0] !== want[0] ||
        emitted[1] !== want[1] || emitted[2] !== want[2] ||
        out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_order: got %0d items v=%b want 3 items v=0",
               emitted.size(), out_valid);
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    in_valid = 1'b1;
    in_data = 32'h1;
    cycle();
    in_data = 32'h2;
    cycle();
    in_data = 32'hD;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got v=%b d=%h r=%b want v=0 d=%h r=1",
               out_valid, out_data, in_ready, BUB);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || out_data === 32'hD) begin
        errors++;
        $display("FAIL flush_leak: got v=%b d=%h want v=0 d=%h",
                 out_valid, out_data, BUB);
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h55;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55) begin
      errors++;
      $display("FAIL drain_one: got v=%b d=%h want v=1 d=00000055",
               out_valid, out_data);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== BUB) begin
      errors++;
      $display("FAIL drain_empty: got v=%b d=%h want v=0 d=%h",
               out_valid, out_data, BUB);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    in_data = 32'h77;
    cycle();
    cycle();
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h r=%b want v=0 d=%h r=1",
               out_valid, out_data, in_ready, BUB);
    end
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    n_rst = 1'b1;
    cycle();
  endtask

`ifdef PIPE_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    in_valid = 1'b1;
    in_data = 32'h99;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (stall_cnt !== CW'(SAT)) begin
      errors++;
      $display("FAIL cnt_sat: got %0d want %0d", stall_cnt, SAT);
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    checks++;
    if (stall_cnt !== CW'(SAT)) begin
      errors++;
      $display("FAIL cnt_flush: got %0d want %0d", stall_cnt, SAT);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d want 0", stall_cnt);
    end
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask
`endif

  task automatic test_random();
    int  bad = 0;
    bit  acc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      acc = in_valid && (mq.size() < 2);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      cycle();
      checks++;
      if (out_valid !== (mq.size() > 0) || out_data !== exp_data() ||
          in_ready !== (mq.size() < 2)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_%0d: got v=%b d=%h r=%b want v=%b d=%h r=%b",
                   i, out_valid, out_data, in_ready, mq.size() > 0,
                   exp_data(), mq.size() < 2);
      end
`ifdef PIPE_STALL_CNT_EN
      checks++;
      if (stall_cnt !== CW'(mcnt)) begin
        errors++;
        $display("FAIL rand_cnt_%0d: got %0d want %0d", i, stall_cnt, mcnt);
      end
`endif
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    mcnt = 0;
    #1;
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_drain();
    test_async_reset();
`ifdef PIPE_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
